// File: rtl/motor_limit_model.sv
// Behavioural model of a motorised axis between two limit switches: stepped position,
// end-of-travel overrun detection and a latched fault that needs an explicit release.
module motor_limit_model #(
  parameter int unsigned TRAVEL      = 100,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned OVERRUN_MAX = 16,
  parameter int unsigned INIT_POS    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            motor_up,
  input  logic                            motor_dn,
  input  logic                            clear_fault,
  output logic                            up_limit,
  output logic                            dn_limit,
  output logic [$clog2(TRAVEL+1)-1:0]     position,
  output logic                            moving,
  output logic [1:0]                      fault_code,
  output logic [1:0]                      model_state
);

  localparam int unsigned PosW  = $clog2(TRAVEL + 1);
  localparam int unsigned PresW = $clog2(STEP_DIV + 1);
  localparam int unsigned OvrW  = $clog2(OVERRUN_MAX + 1);

  localparam logic [PosW-1:0]  TopPos   = PosW'(TRAVEL);
  localparam logic [PosW-1:0]  InitPos  = PosW'(INIT_POS);
  localparam logic [PresW-1:0] StepLast = PresW'(STEP_DIV - 1);
  localparam logic [OvrW-1:0]  OvrMax   = OvrW'(OVERRUN_MAX);

  localparam logic [1:0] FaultNone  = 2'b00;
  localparam logic [1:0] FaultBoth  = 2'b01;
  localparam logic [1:0] FaultUpOvr = 2'b10;
  localparam logic [1:0] FaultDnOvr = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoveUp = 2'd1,
    StMoveDn = 2'd2,
    StFault  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [OvrW-1:0]  ovr_q, ovr_d;
  logic [1:0]       fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    ovr_d   = ovr_q;
    fault_d = fault_q;

    // Both motors driven beats every other transition outside FAULT.
    if (state_q != StFault && motor_up && motor_dn) begin
      state_d = StFault;
      fault_d = FaultBoth;
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_d = '0;
          ovr_d   = '0;
          if (motor_up)      state_d = StMoveUp;
          else if (motor_dn) state_d = StMoveDn;
        end
        StMoveUp: begin
          if (!motor_up) begin
            state_d = StIdle;
          end else if (pos_q != TopPos) begin
            if (presc_q == StepLast) begin
              pos_d   = pos_q + 1'b1;
              presc_d = '0;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end else begin
            presc_d = '0;
            ovr_d   = (ovr_q == OvrMax) ? ovr_q : ovr_q + 1'b1;
            if (ovr_d == OvrMax) begin
              state_d = StFault;
              fault_d = FaultUpOvr;
            end
          end
        end
        StMoveDn: begin
          if (!motor_dn) begin
            state_d = StIdle;
          end else if (pos_q != '0) begin
            if (presc_q == StepLast) begin
              pos_d   = pos_q - 1'b1;
              presc_d = '0;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end else begin
            presc_d = '0;
            ovr_d   = (ovr_q == OvrMax) ? ovr_q : ovr_q + 1'b1;
            if (ovr_d == OvrMax) begin
              state_d = StFault;
              fault_d = FaultDnOvr;
            end
          end
        end
        StFault: begin
          if (clear_fault && !motor_up && !motor_dn) begin
            state_d = StIdle;
            fault_d = FaultNone;
          end
        end
      endcase
    end

    // Partial step progress and overrun history never survive leaving a move state.
    if (state_d != StMoveUp && state_d != StMoveDn) begin
      presc_d = '0;
      ovr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pos_q    <= InitPos;
      presc_q  <= '0;
      ovr_q    <= '0;
      fault_q  <= FaultNone;
      moving   <= 1'b0;
      up_limit <= (InitPos == TopPos);
      dn_limit <= (InitPos == '0);
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      presc_q  <= presc_d;
      ovr_q    <= ovr_d;
      fault_q  <= fault_d;
      moving   <= (state_d == StMoveUp) || (state_d == StMoveDn);
      up_limit <= (pos_d == TopPos);
      dn_limit <= (pos_d == '0);
    end
  end

  assign position    = pos_q;
  assign fault_code  = fault_q;
  assign model_state = state_q;

endmodule

// File: tb/tb_motor_limit_model.sv
// Scoreboard bench for motor_limit_model: a cycle model queues the expected outputs per edge,
// a monitor pops and compares them; directed checks pin the key timing points.
module tb_motor_limit_model;

  localparam int TRAVEL = 8;
  localparam int STEP_DIV = 2;
  localparam int OVR_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       motor_up = 1'b0;
  logic       motor_dn = 1'b0;
  logic       clear_fault = 1'b0;
  logic       up_limit, dn_limit, moving;
  logic [3:0] position;
  logic [1:0] fault_code, model_state;

  motor_limit_model #(
    .TRAVEL      (TRAVEL),
    .STEP_DIV    (STEP_DIV),
    .OVERRUN_MAX (OVR_MAX),
    .INIT_POS    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .motor_up    (motor_up),
    .motor_dn    (motor_dn),
    .clear_fault (clear_fault),
    .up_limit    (up_limit),
    .dn_limit    (dn_limit),
    .position    (position),
    .moving      (moving),
    .fault_code  (fault_code),
    .model_state (model_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] pos;
    logic [1:0] fc;
    logic       mv;
    logic       ul;
    logic       dl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference state of the axis
  int m_state, m_pos, m_pre, m_ovr, m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_pre = 0; m_ovr = 0; m_fault = 0;
  endtask

  task automatic model_step(input logic up, input logic dn, input logic clr);
    if (m_state != 3 && up && dn) begin
      m_state = 3; m_fault = 1;
    end else begin
      case (m_state)
        0: begin
          if (up)      m_state = 1;
          else if (dn) m_state = 2;
        end
        1: begin
          if (!up) m_state = 0;
          else if (m_pos < TRAVEL) begin
            if (m_pre == STEP_DIV - 1) begin m_pos++; m_pre = 0; end
            else m_pre++;
          end else begin
            m_ovr++;
            if (m_ovr >= OVR_MAX) begin m_state = 3; m_fault = 2; end
          end
        end
        2: begin
          if (!dn) m_state = 0;
          else if (m_pos > 0) begin
            if (m_pre == STEP_DIV - 1) begin m_pos--; m_pre = 0; end
            else m_pre++;
          end else begin
            m_ovr++;
            if (m_ovr >= OVR_MAX) begin m_state = 3; m_fault = 3; end
          end
        end
        default: begin
          if (clr && !up && !dn) begin m_state = 0; m_fault = 0; end
        end
      endcase
    end
    if (m_state == 0 || m_state == 3) begin m_pre = 0; m_ovr = 0; end
  endtask

  // Drive one cycle of inputs and queue what the following edge must produce.
  task automatic cyc(input logic up, input logic dn, input logic clr);
    exp_t e;
    @(negedge clk);
    motor_up = up; motor_dn = dn; clear_fault = clr;
    model_step(up, dn, clr);
    e.st  = 2'(m_state);
    e.pos = 4'(m_pos);
    e.fc  = 2'(m_fault);
    e.mv  = (m_state == 1 || m_state == 2);
    e.ul  = (m_pos == TRAVEL);
    e.dl  = (m_pos == 0);
    exp_q.push_back(e);
  endtask

  task automatic cycn(input int n, input logic up, input logic dn, input logic clr);
    for (int i = 0; i < n; i++) cyc(up, dn, clr);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Reset between edges; outputs must change before the next rising edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    motor_up = 1'b0; motor_dn = 1'b0; clear_fault = 1'b0;
    #1;
    check({tag, "_pos"}, 32'(position), 0);
    check({tag, "_dn_lim"}, 32'(dn_limit), 1);
    check({tag, "_up_lim"}, 32'(up_limit), 0);
    check({tag, "_state"}, 32'(model_state), 0);
    check({tag, "_fault"}, 32'(fault_code), 0);
    check({tag, "_moving"}, 32'(moving), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_state", 32'(model_state), 32'(e.st));
        check("sb_pos", 32'(position), 32'(e.pos));
        check("sb_fault", 32'(fault_code), 32'(e.fc));
        check("sb_moving", 32'(moving), 32'(e.mv));
        check("sb_up_lim", 32'(up_limit), 32'(e.ul));
        check("sb_dn_lim", 32'(dn_limit), 32'(e.dl));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int hold;
    logic ru, rd, rc;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("rst_pos", 32'(position), 0);
    check("rst_dn_lim", 32'(dn_limit), 1);
    check("rst_up_lim", 32'(up_limit), 0);
    check("rst_state", 32'(model_state), 0);
    @(negedge clk);
    rst = 1'b0;

    cycn(5, 0, 0, 0);
    // Full upward travel: entry edge then 16 edges to reach the top
    cyc(1, 0, 0);
    sync();
    check("up_entry_state", 32'(model_state), 1);
    cycn(2, 1, 0, 0);
    sync();
    check("first_step_pos", 32'(position), 1);
    check("first_step_dn_lim", 32'(dn_limit), 0);
    cycn(14, 1, 0, 0);
    sync();
    check("top_pos", 32'(position), 8);
    check("top_up_lim", 32'(up_limit), 1);
    cycn(3, 1, 0, 0);
    sync();
    check("pre_ovr_state", 32'(model_state), 1);
    cyc(1, 0, 0);
    sync();
    check("up_ovr_state", 32'(model_state), 3);
    check("up_ovr_code", 32'(fault_code), 2);
    check("up_ovr_pos", 32'(position), 8);
    cyc(0, 0, 1);
    sync();
    check("clr_state", 32'(model_state), 0);
    check("clr_code", 32'(fault_code), 0);

    // Down to 3, then both motors
    cycn(11, 0, 1, 0);
    cyc(0, 0, 0);
    sync();
    check("at3_pos", 32'(position), 3);
    cyc(1, 1, 0);
    sync();
    check("both_code", 32'(fault_code), 1);
    check("both_pos", 32'(position), 3);
    cyc(1, 0, 1);
    sync();
    check("clr_blocked_state", 32'(model_state), 3);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    // Back to 0, short up move, then down
    cycn(7, 0, 1, 0);
    cyc(0, 0, 0);
    cycn(3, 1, 0, 0);
    cyc(0, 0, 0);
    sync();
    check("short_pos", 32'(position), 1);
    check("short_state", 32'(model_state), 0);
    cycn(2, 0, 1, 0);
    sync();
    check("dn_pre_pos", 32'(position), 1);
    cyc(0, 1, 0);
    sync();
    check("dn_land_pos", 32'(position), 0);
    cyc(0, 0, 0);

    // Reach 5 while moving down, then reset between edges
    cycn(13, 1, 0, 0);
    cyc(0, 0, 0);
    cycn(4, 0, 1, 0);
    sync();
    check("mid_dn_pos", 32'(position), 5);
    check("mid_dn_state", 32'(model_state), 2);
    do_reset("async_rst");
    // First edge after reset starts from IDLE; then overrun at the bottom
    cycn(5, 0, 1, 0);
    sync();
    check("dn_ovr_code", 32'(fault_code), 3);
    cyc(0, 0, 1);

    // Random held patterns
    for (int k = 0; k < 120; k++) begin
      hold = $urandom_range(1, 9);
      ru = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 3) == 0);
      cycn(hold, ru, rd, rc);
    end
    cycn(2, 0, 0, 1);
    sync();
    check("drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_limit_model.md
MOTOR_LIMIT_MODEL -- requirements
Module: motor_limit_model

Interface
REQ-001 The block SHALL have parameter TRAVEL, default 100: top position in steps; legal range >= 2.
REQ-002 The block SHALL have parameter STEP_DIV, default 4: clock cycles per position step; legal range >= 1.
REQ-003 The block SHALL have parameter OVERRUN_MAX, default 16: number of cycles a motor may drive into its active limit before a fault is raised.
REQ-004 The block SHALL have parameter INIT_POS, default 0: position loaded on reset; legal range 0..TRAVEL.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port motor_up, input, 1 bit: drive the position upward.
REQ-008 The block SHALL have port motor_dn, input, 1 bit: drive the position downward.
REQ-009 The block SHALL have port clear_fault, input, 1 bit: fault release request.
REQ-010 The block SHALL have port up_limit, output reg, 1 bit: high exactly when position == TRAVEL.
REQ-011 The block SHALL have port dn_limit, output reg, 1 bit: high exactly when position == 0.
REQ-012 The block SHALL have port position, output reg, width $clog2(TRAVEL+1): current position.
REQ-013 The block SHALL have port moving, output reg, 1 bit: high in states MOVE_UP and MOVE_DN.
REQ-014 The block SHALL have port fault_code, output reg, 2 bits, encoded as:
- 00: none
- 01: both motors driven
- 10: up overrun
- 11: down overrun
REQ-015 The block SHALL have port model_state, output reg, 2 bits, encoded as:
- IDLE = 0
- MOVE_UP = 1
- MOVE_DN = 2
- FAULT = 3

Function
REQ-016 All outputs SHALL be registered. up_limit and dn_limit SHALL be updated from the next-position value, so they agree with position in every cycle.
REQ-017 Both motor_up and motor_dn high in IDLE, MOVE_UP or MOVE_DN SHALL cause FAULT with fault_code=01 on the next edge. This rule has priority over every other transition.
REQ-018 IDLE SHALL transition as follows:
- motor_up=1 -> MOVE_UP
- otherwise motor_dn=1 -> MOVE_DN
- otherwise stay
- On entry to MOVE_UP or MOVE_DN: prescaler=0, overrun counter=0.
REQ-019 In MOVE_UP, when motor_up=1 and position < TRAVEL:
- if prescaler == STEP_DIV-1: position+1 and prescaler=0
- otherwise: prescaler+1
- First step therefore lands STEP_DIV cycles after entering MOVE_UP.
REQ-020 In MOVE_UP, when motor_up=1 and position == TRAVEL:
- position held, prescaler held at 0, overrun counter+1 each cycle.
- When the counter reaches OVERRUN_MAX: FAULT with fault_code=10.
REQ-021 MOVE_DN SHALL mirror REQ-019 and REQ-020:
- position decrements toward 0, saturating at 0.
- Overrun at position 0 raises FAULT with fault_code=11.
REQ-022 In MOVE_UP with motor_up=0, or in MOVE_DN with motor_dn=0, the block SHALL go to IDLE on the next edge.
- Any partial prescaler count is discarded.
- Direction reversal always passes through one IDLE cycle.
REQ-023 Position SHALL never leave 0..TRAVEL; no wrap-around.
REQ-024 In FAULT:
- position frozen, moving=0, fault_code held.
- Exit to IDLE, with fault_code=00, only when clear_fault=1, motor_up=0 and motor_dn=0 are sampled in the same cycle.
- clear_fault has no effect in any other state.
REQ-025 The overrun counter SHALL saturate at OVERRUN_MAX and SHALL be cleared whenever the state is not MOVE_UP or MOVE_DN.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force:
- model_state=IDLE, position=INIT_POS, prescaler=0, overrun counter=0
- fault_code=00, moving=0
- up_limit=(INIT_POS==TRAVEL), dn_limit=(INIT_POS==0)
REQ-027 Reset asserted mid-move or in FAULT SHALL discard all progress. After rst drops, the first rising edge SHALL evaluate the inputs from IDLE.

Verification (TRAVEL=8, STEP_DIV=2, OVERRUN_MAX=4, INIT_POS=0)
REQ-028 Reset release, no motor input -> position=0, dn_limit=1, up_limit=0, fault_code=00, model_state=0, held indefinitely.
REQ-029 motor_up held high from position 0 ->
- model_state=1 one edge later.
- position increments every 2 cycles.
- dn_limit falls with position=1.
- up_limit rises with position=8, 16 cycles after entering MOVE_UP.
REQ-030 motor_up held 4 further cycles at position 8 -> model_state=3, fault_code=10, position stays 8. Then clear_fault=1 with both motors low -> model_state=0, fault_code=00 next edge.
REQ-031 From IDLE at position 3, motor_up=motor_dn=1 -> FAULT with fault_code=01 next edge, position 3. clear_fault=1 while motor_up is still high -> stays in FAULT.
REQ-032 motor_up high, then dropped after 3 cycles at position 0 -> position=1, IDLE next edge, prescaler cleared. A subsequent motor_dn takes 2 cycles to reach position 0.
REQ-033 rst pulsed at position 5 during MOVE_DN, between clock edges -> position=0, dn_limit=1, model_state=0 immediately, before the next clk edge.
